// File: rtl/pixel_plot_sink.sv
// Pixel-plot stream sink: FIFO-buffers plot requests, range-checks them, converts (x,y) to a linear
// framebuffer address and issues single-pixel writes that hold while fb_stall is high.
// Optional macro PIXEL_SINK_TRANSPARENT_EN: in-range plots with colour TRANSPARENT_KEY are accepted but not written.
module pixel_plot_sink #(
    parameter int          SCREEN_W        = 160,
    parameter int          SCREEN_H        = 120,
    parameter int          FIFO_DEPTH      = 16,
    parameter logic [11:0] TRANSPARENT_KEY = 12'h000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        plot,
    input  logic [7:0]  x_in,
    input  logic [6:0]  y_in,
    input  logic [11:0] colour_in,
    output logic        ready,
    output logic        empty,
    input  logic        fb_stall,
    output logic        fb_we,
    output logic [14:0] fb_addr,
    output logic [11:0] fb_colour,
    output logic [7:0]  drop_count
);

    localparam int         AW    = $clog2(FIFO_DEPTH);
    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

`ifdef PIXEL_SINK_TRANSPARENT_EN
    localparam logic KEY_EN = 1'b1;
`else
    localparam logic KEY_EN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0]  x;
        logic [6:0]  y;
        logic [11:0] colour;
    } pix_t;

    typedef enum logic {IDLE, WRITE} state_t;

    pix_t          mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    state_t        state;
    state_t        state_nxt;
    logic          in_range;
    logic          is_key;
    logic          push;
    logic          pop;
    logic          fifo_nonempty;
    pix_t          head;
    logic [14:0]   head_addr;

    assign in_range      = ({1'b0, x_in} < X_LIM) && ({1'b0, y_in} < Y_LIM);
    assign is_key        = KEY_EN && (colour_in == TRANSPARENT_KEY);
    assign fifo_nonempty = (count != '0);
    // Depth is a power of two and count never exceeds it, so the MSB alone flags "full".
    assign ready         = !count[AW];
    assign push          = plot && ready && in_range && !is_key;
    assign fb_we         = (state == WRITE);
    assign empty         = !fifo_nonempty && !fb_we;

    assign head      = mem[rd_ptr];
    assign head_addr = {8'b0, head.y} * 15'(SCREEN_W) + {7'b0, head.x};

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_nonempty) begin
                    pop       = 1'b1;
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                // A stalled write holds the output; only an acknowledged write frees it for the next entry.
                if (!fb_stall) begin
                    if (fifo_nonempty) begin
                        pop = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{x: x_in, y: y_in, colour: colour_in};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fb_addr    <= '0;
            fb_colour  <= '0;
            drop_count <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + 1'b1;
                fb_addr   <= head_addr;
                fb_colour <= head.colour;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (plot && (!ready || !in_range) && (drop_count != 8'hFF)) begin
                drop_count <= drop_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_plot_sink.sv
// Directed bench for pixel_plot_sink: a queue of expected framebuffer writes plus a drop counter model,
// checked every cycle by one compare process, alongside hand-computed literal expectations.
module tb_pixel_plot_sink;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

`ifdef PIXEL_SINK_TRANSPARENT_EN
    localparam bit KEY_EN = 1'b1;
`else
    localparam bit KEY_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        plot;
    logic [7:0]  x_in;
    logic [6:0]  y_in;
    logic [11:0] colour_in;
    logic        ready;
    logic        empty;
    logic        fb_stall;
    logic        fb_we;
    logic [14:0] fb_addr;
    logic [11:0] fb_colour;
    logic [7:0]  drop_count;

    pixel_plot_sink dut (
        .clk        (clk),
        .reset      (reset),
        .plot       (plot),
        .x_in       (x_in),
        .y_in       (y_in),
        .colour_in  (colour_in),
        .ready      (ready),
        .empty      (empty),
        .fb_stall   (fb_stall),
        .fb_we      (fb_we),
        .fb_addr    (fb_addr),
        .fb_colour  (fb_colour),
        .drop_count (drop_count)
    );

    typedef struct {
        int addr;
        int colour;
    } wr_t;

    wr_t exp_q[$];
    int  m_drop = 0;
    int  n_vec  = 0;
    int  n_fail = 0;
    int  n_wr   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Completed writes (fb_we high, no stall at the coming edge) must match the acceptance-order queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (fb_we && !fb_stall) begin
                n_wr++;
                if (exp_q.size() == 0) begin
                    chk("spurious_write", {17'b0, fb_addr}, 32'hFFFF_FFFF);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr", {17'b0, fb_addr}, e.addr);
                    chk("write_colour", {20'b0, fb_colour}, e.colour);
                end
            end
            chk("drop_count", {24'b0, drop_count}, m_drop);
        end
    end

    task automatic plot_px(input int x, input int y, input int c, input bit exp_ready);
        plot      = 1'b1;
        x_in      = 8'(x);
        y_in      = 7'(y);
        colour_in = 12'(c);
        chk("ready_at_plot", {31'b0, ready}, {31'b0, exp_ready});
        @(posedge clk); #1;
        plot = 1'b0;
        if (!exp_ready || x >= SCREEN_W || y >= SCREEN_H) begin
            m_drop = (m_drop == 255) ? 255 : m_drop + 1;
        end else if (!(KEY_EN && c == 0)) begin
            exp_q.push_back('{y * SCREEN_W + x, c});
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_drop = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        int wr_base;
        reset     = 1'b1;
        plot      = 1'b0;
        x_in      = '0;
        y_in      = '0;
        colour_in = '0;
        fb_stall  = 1'b0;
        #3;
        chk("rst_fb_we", {31'b0, fb_we}, 0);
        chk("rst_fb_addr", {17'b0, fb_addr}, 0);
        chk("rst_fb_colour", {20'b0, fb_colour}, 0);
        chk("rst_drop", {24'b0, drop_count}, 0);
        chk("rst_ready", {31'b0, ready}, 1);
        chk("rst_empty", {31'b0, empty}, 1);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single pixel: accepted at edge N, fb_we high after edge N+1.
        plot_px(5, 2, 12'hFFF, 1'b1);
        chk("lat_we_early", {31'b0, fb_we}, 0);
        @(posedge clk); #1;
        chk("lat_we", {31'b0, fb_we}, 1);
        chk("lat_addr", {17'b0, fb_addr}, 325);
        chk("lat_colour", {20'b0, fb_colour}, 12'hFFF);
        @(posedge clk); #1;
        chk("single_done_we", {31'b0, fb_we}, 0);
        chk("single_done_empty", {31'b0, empty}, 1);

        // Stalled fill: the first pixel moves into the held output, so 17 are accepted before full.
        fb_stall = 1'b1;
        for (int i = 0; i < 17; i++) begin
            plot_px(i * 9, 100 - i, 12'h100 + i, 1'b1);
        end
        chk("full_ready", {31'b0, ready}, 0);
        plot_px(1, 1, 12'h123, 1'b0);
        chk("full_drop", {24'b0, drop_count}, 1);
        wr_base  = n_wr;
        fb_stall = 1'b0;
        for (int i = 0; i < 17; i++) begin
            chk("b2b_we", {31'b0, fb_we}, 1);
            @(posedge clk); #1;
        end
        chk("b2b_count", n_wr - wr_base, 17);
        chk("b2b_idle", {31'b0, fb_we}, 0);
        chk("b2b_empty", {31'b0, empty}, 1);

        // Out-of-range plots are counted, never written.
        do_reset();
        plot_px(160, 0, 12'hABC, 1'b1);
        plot_px(0, 120, 12'hABC, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("oor_drop", {24'b0, drop_count}, 2);
        chk("oor_ready", {31'b0, ready}, 1);
        chk("oor_we", {31'b0, fb_we}, 0);

        // Four-pixel burst with stall toggling every cycle.
        wr_base = n_wr;
        for (int i = 0; i < 14; i++) begin
            plot = (i < 4);
            x_in = 8'(10 + i);
            y_in = 7'(3 + i);
            colour_in = 12'(12'hA00 + i);
            fb_stall = (i % 2 == 1);
            @(posedge clk); #1;
            if (i < 4) exp_q.push_back('{(3 + i) * SCREEN_W + 10 + i, 12'hA00 + i});
        end
        plot = 1'b0;
        fb_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("burst_count", n_wr - wr_base, 4);
        chk("burst_drained", exp_q.size(), 0);

        // Reset while a write is held and entries are queued.
        fb_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            plot_px(20 + i, 7, 12'h050 + i, 1'b1);
        end
        @(posedge clk); #1;
        chk("pre_rst_we", {31'b0, fb_we}, 1);
        #2;
        reset = 1'b1;
        exp_q.delete();
        m_drop = 0;
        #1;
        chk("mid_rst_we", {31'b0, fb_we}, 0);
        chk("mid_rst_empty", {31'b0, empty}, 1);
        chk("mid_rst_ready", {31'b0, ready}, 1);
        @(posedge clk); #1;
        reset = 1'b0;
        fb_stall = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("post_rst_we", {31'b0, fb_we}, 0);
        chk("post_rst_empty", {31'b0, empty}, 1);

        // drop_count saturates at 255.
        for (int i = 0; i < 260; i++) begin
            plot_px(200, 5, 12'h777, 1'b1);
        end
        chk("drop_sat", {24'b0, drop_count}, 255);

        // Colour 000: transparent when the feature is built in, an ordinary pixel otherwise.
        do_reset();
        wr_base = n_wr;
        plot_px(3, 4, 12'h000, 1'b1);
        plot_px(2, 1, 12'h0F0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        chk("key_writes", n_wr - wr_base, KEY_EN ? 1 : 2);
        chk("key_drop", {24'b0, drop_count}, 0);
        chk("key_last_addr", {17'b0, fb_addr}, 162);

        chk("final_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
